// File: rtl/spi_link_pkg.sv
// Shared widths and state encoding for the SPI word link.
package spi_link_pkg;

    localparam int WORD_W    = 16;
    localparam int BIT_CNT_W = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } link_state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Synchroniser for one asynchronous SPI pin plus registered level and edge strobes.
// level, rise and fall all come from flops, so every pin presents the same delay.
module spi_pin_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;

    // Flops clear to 0: a chip select held low through reset yields no falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync  <= {sync[STAGES-2:0], pin};
            level <= sync[STAGES-1];
            rise  <= sync[STAGES-1] & ~level;
            fall  <= ~sync[STAGES-1] & level;
        end
    end

endmodule

// File: rtl/spi_word_link.sv
// SPI mode-0 slave: oversampled pins, 16-bit rx deserialiser with small FIFO, tx serialiser.
// Define SPI_ERR_FLAGS_EN to build the sticky rx_overrun / tx_underrun flags.
module spi_word_link
    import spi_link_pkg::*;
#(
    parameter int                SYNC_STAGES = 2,
    parameter int                RX_DEPTH    = 2,
    parameter logic [WORD_W-1:0] TX_IDLE     = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_sck,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              start,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [WORD_W-1:0] tx_data,
    input  logic              tx_ready,
    output logic              tx_take,
    output logic              rx_overrun,
    output logic              tx_underrun
);

    localparam int PTR_W = $clog2(RX_DEPTH);

    logic sck_lvl, sck_rise, sck_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic unused_sync;

    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sck_sync (
        .clk(clk), .reset(reset), .pin(spi_sck),
        .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
    );
    // cs_n falling edge opens a frame, rising edge closes it.
    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk(clk), .reset(reset), .pin(spi_cs_n),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );
    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_mosi_sync (
        .clk(clk), .reset(reset), .pin(spi_mosi),
        .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign unused_sync = ^{sck_lvl, cs_lvl, mosi_rise, mosi_fall};

    link_state_e          state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [WORD_W-1:0]    rx_sh, tx_sh;
    logic                 miso_oe_q;
    logic                 tx_load, tx_shift, rx_shift, word_done;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        tx_load   = 1'b0;
        tx_shift  = 1'b0;
        rx_shift  = 1'b0;
        word_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = ACTIVE;
                    start   = 1'b1;
                    tx_load = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end else begin
                    if (sck_rise) begin
                        rx_shift  = 1'b1;
                        word_done = (bit_cnt == '1);
                    end
                    // Load on the first falling edge after a word boundary, shift otherwise.
                    if (sck_fall) begin
                        if (bit_cnt == '0) tx_load  = 1'b1;
                        else               tx_shift = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx_take     = tx_load & tx_ready;
    assign spi_miso    = tx_sh[WORD_W-1];
    assign spi_miso_oe = miso_oe_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt   <= '0;
            rx_sh     <= '0;
            tx_sh     <= '0;
            miso_oe_q <= 1'b0;
        end else begin
            if (start) begin
                bit_cnt   <= '0;
                miso_oe_q <= 1'b1;
            end else if (cs_rise) begin
                // Any partial word in rx_sh is abandoned; bit_cnt=0 restarts framing.
                bit_cnt   <= '0;
                miso_oe_q <= 1'b0;
            end else if (rx_shift) begin
                rx_sh   <= {rx_sh[WORD_W-2:0], mosi_lvl};
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
            if (tx_load)       tx_sh <= tx_ready ? tx_data : TX_IDLE;
            else if (tx_shift) tx_sh <= {tx_sh[WORD_W-2:0], 1'b0};
        end
    end

    // rx FIFO: pointers wrap naturally because RX_DEPTH is a power of two.
    logic [WORD_W-1:0] mem [RX_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;
    logic              full, push, pop;

    assign full     = (count == (PTR_W+1)'(RX_DEPTH));
    assign rx_valid = (count != '0);
    assign pop      = rx_valid & rx_ready;
    assign push     = word_done & (~full | pop);
    assign rx_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RX_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {rx_sh[WORD_W-2:0], mosi_lvl};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef SPI_ERR_FLAGS_EN
    logic drop;
    assign drop = word_done & full & ~pop;

    // A set in the start cycle wins: an underrun on the opening load belongs to the new frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            if (drop)       rx_overrun <= 1'b1;
            else if (start) rx_overrun <= 1'b0;
            if (tx_load && !tx_ready) tx_underrun <= 1'b1;
            else if (start)           tx_underrun <= 1'b0;
        end
    end
`else
    assign rx_overrun  = 1'b0;
    assign tx_underrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_word_link.sv
// Directed bench for spi_word_link: SCK at clk/8, hand-computed words and flag values.
module tb_spi_word_link;

    logic        clk = 1'b0;
    logic        reset;
    logic        spi_sck, spi_cs_n, spi_mosi, spi_miso, spi_miso_oe;
    logic        start, rx_valid, rx_ready, tx_ready, tx_take;
    logic        rx_overrun, tx_underrun;
    logic [15:0] rx_data, tx_data;

`ifdef SPI_ERR_FLAGS_EN
    localparam logic FLAGS = 1'b1;
`else
    localparam logic FLAGS = 1'b0;
`endif

    always #5 clk = ~clk;

    spi_word_link dut (
        .clk(clk), .reset(reset),
        .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_ready(tx_ready), .tx_take(tx_take),
        .rx_overrun(rx_overrun), .tx_underrun(tx_underrun)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int start_cnt = 0;
    int take_cnt = 0;

    always @(negedge clk) begin
        if (start)   start_cnt <= start_cnt + 1;
        if (tx_take) take_cnt  <= take_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCK period: MOSI set in the low phase, MISO sampled at the end of the high phase.
    task automatic spi_bit(input logic b, output logic m);
        spi_mosi = b;
        tick(4);
        spi_sck = 1'b1;
        tick(4);
        m = spi_miso;
        spi_sck = 1'b0;
    endtask

    task automatic spi_word(input logic [15:0] w, output logic [15:0] m);
        logic b;
        for (int i = 15; i >= 0; i--) begin
            spi_bit(w[i], b);
            m[i] = b;
        end
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        tick(8);
    endtask

    task automatic cs_high();
        tick(4);
        spi_cs_n = 1'b1;
        tick(8);
    endtask

    task automatic pop();
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [15:0] m, m1, m2, m3, w;
        logic        b;
        int          lat;

        reset = 1'b1; spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
        rx_ready = 1'b0; tx_ready = 1'b0; tx_data = 16'h0000;
        tick(4);
        chk("rst_miso_oe", spi_miso_oe, 0);
        chk("rst_miso", spi_miso, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 16'h0000);
        chk("rst_flags", {rx_overrun, tx_underrun, start, tx_take}, 0);
        reset = 1'b0;
        tick(8);

        // Frame A: load 0x1234, receive 0xA503 with latency check, then an idle word.
        tx_ready = 1'b1; tx_data = 16'h1234;
        cs_low();
        chk("a_start_cnt", start_cnt, 1);
        chk("a_take_cnt", take_cnt, 1);
        chk("a_miso_oe", spi_miso_oe, 1);
        tx_ready = 1'b0;
        w = 16'hA503;
        for (int i = 15; i >= 1; i--) begin
            spi_bit(w[i], b);
            m[i] = b;
        end
        spi_mosi = w[0];
        tick(4);
        spi_sck = 1'b1;
        lat = 0;
        while (!rx_valid && lat < 20) begin
            tick(1);
            lat++;
        end
        chk("a_rx_latency", lat, 4);
        if (lat < 4) tick(4 - lat);
        m[0] = spi_miso;
        spi_sck = 1'b0;
        tick(6);
        chk("a_rx_data", rx_data, 16'hA503);
        chk("a_miso_word", m, 16'h1234);
        chk("a_take_once", take_cnt, 1);
        chk("a_underrun", tx_underrun, FLAGS);
        pop();
        chk("a_popped", rx_valid, 0);
        spi_word(16'h5AC3, m);
        tick(6);
        chk("a_idle_miso", m, 16'h0000);
        chk("a_rx_data2", rx_data, 16'h5AC3);
        pop();
        cs_high();
        chk("a_oe_off", spi_miso_oe, 0);
        chk("a_underrun_sticky", tx_underrun, FLAGS);

        // Frame B: start clears underrun; three words into a 2-deep FIFO.
        tx_ready = 1'b1; tx_data = 16'hBEEF;
        cs_low();
        chk("b_start_cnt", start_cnt, 2);
        chk("b_underrun_clr", tx_underrun, 0);
        spi_word(16'h1111, m1);
        spi_word(16'h2222, m2);
        spi_word(16'h3333, m3);
        tick(6);
        chk("b_miso_w1", m1, 16'hBEEF);
        chk("b_miso_w2", m2, 16'hBEEF);
        chk("b_take_cnt", take_cnt, 5);
        chk("b_overrun", rx_overrun, FLAGS);
        chk("b_fifo_0", rx_data, 16'h1111);
        pop();
        chk("b_fifo_1", rx_data, 16'h2222);
        pop();
        chk("b_fifo_empty", rx_valid, 0);
        cs_high();
        tx_ready = 1'b0;

        // Frame C: partial 9-bit word is discarded at cs_n rise.
        cs_low();
        chk("c_overrun_clr", rx_overrun, 0);
        chk("c_underrun", tx_underrun, FLAGS);
        for (int i = 0; i < 9; i++) spi_bit(1'b1, b);
        cs_high();
        chk("c_no_partial", rx_valid, 0);

        // Frame D: clean framing after the aborted word.
        cs_low();
        spi_word(16'hFFFF, m);
        tick(6);
        chk("d_rx_valid", rx_valid, 1);
        chk("d_rx_ffff", rx_data, 16'hFFFF);
        pop();
        spi_word(16'h8001, m);
        tick(6);
        chk("d_rx_8001", rx_data, 16'h8001);
        pop();
        cs_high();

        // Frame E: reset mid-word; CS_N held low must not open a frame.
        cs_low();
        chk("e_start_cnt", start_cnt, 5);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, b);
        reset = 1'b1;
        tick(2);
        chk("e_rst_outs", {spi_miso_oe, spi_miso, rx_valid, start}, 0);
        reset = 1'b0;
        tick(10);
        spi_word(16'h1357, m);
        tick(6);
        chk("e_ignored_rx", rx_valid, 0);
        chk("e_no_start", start_cnt, 5);
        chk("e_no_oe", spi_miso_oe, 0);
        cs_high();
        cs_low();
        chk("e_restart", start_cnt, 6);
        spi_word(16'h2468, m);
        tick(6);
        chk("e_rx_2468", rx_data, 16'h2468);
        cs_high();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
